// File: rtl/dht_sensor_reader.sv
// Multi-channel single-wire (DHT11/DHT22 style) humidity/temperature reader.
// A 1 us tick times every phase: the host start pulse, the sensor response,
// and the 40 data bits. Bits are decoded from their high time, and the
// checksum byte is verified before data is published.
module dht_sensor_reader #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int NUM_CH        = 4,
  parameter int POWER_ON_US   = 1_000_000,
  parameter int START_LOW_US  = 20_000,
  parameter int BIT_THRESH_US = 40,
  parameter int TIMEOUT_US    = 100,
  parameter int HOLDOFF_US    = 2_000_000,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [NUM_CH-1:0] dht_in,
  output logic [NUM_CH-1:0] dht_oe,
  output logic              busy,
  output logic              done,
  output logic [31:0]       data,
  output logic [CH_W-1:0]   data_ch,
  output logic              checksum_ok,
  output logic              timeout_err
);

  localparam int DIV   = CLK_HZ / 1_000_000;
  localparam int DIV_W = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  // Each limit is "last tick index" so a phase lasts exactly N microseconds.
  localparam logic [31:0] PWR_LAST   = 32'(POWER_ON_US - 1);
  localparam logic [31:0] START_LAST = 32'(START_LOW_US - 1);
  localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_US - 1);
  localparam logic [31:0] HOLD_LAST  = 32'(HOLDOFF_US - 1);
  localparam logic [31:0] THRESH     = 32'(BIT_THRESH_US);

  typedef enum logic [3:0] {
    POWERUP, IDLE, START_LOW, WAIT_RESP_LOW, WAIT_RESP_HIGH, WAIT_RESP_END,
    BIT_LOW, BIT_HIGH, CHECK, DONE, HOLDOFF
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q;
  logic [31:0]       us_cnt_q;
  logic              tick;
  logic [NUM_CH-1:0] sync_p0, sync_p1;
  logic              line_cur, line_p2;
  logic              rise, fall;
  logic [CH_W-1:0]   ch_q;
  logic [5:0]        bit_cnt_q;
  logic [39:0]       shift_q;
  logic [31:0]       ch_sel_ext;
  logic              ch_bad;
  logic              to_hit;

  // Modulo-256 sum of the four payload bytes against the trailing checksum byte.
  function automatic logic sum_match(input logic [39:0] f);
    logic [7:0] s;
    s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return (s == f[7:0]);
  endfunction

  // True on the tick that completes the requested number of microseconds.
  function automatic logic elapsed(input logic [31:0] cnt, input logic [31:0] last,
                                   input logic t);
    return t && (cnt >= last);
  endfunction

  assign tick       = (div_cnt_q == DIV_LAST);
  assign ch_sel_ext = 32'(ch_sel);
  assign ch_bad     = (ch_sel_ext >= 32'(NUM_CH));
  assign line_cur   = sync_p1[ch_q];
  assign rise       = line_cur & ~line_p2;
  assign fall       = ~line_cur & line_p2;
  assign to_hit     = elapsed(us_cnt_q, TO_LAST, tick);

  // Two-flop synchronizer on every line, then previous value of the selected line.
  always_ff @(posedge clock) begin
    sync_p0 <= dht_in;
    sync_p1 <= sync_p0;
    line_p2 <= line_cur;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= POWERUP;
    else       state_q <= state_d;
  end

  // Next-state logic; edge checks take priority over timeouts on the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      POWERUP:        if (elapsed(us_cnt_q, PWR_LAST, tick)) state_d = IDLE;
      IDLE:           if (start) state_d = ch_bad ? DONE : START_LOW;
      START_LOW:      if (elapsed(us_cnt_q, START_LAST, tick)) state_d = WAIT_RESP_LOW;
      WAIT_RESP_LOW:  if (fall) state_d = WAIT_RESP_HIGH; else if (to_hit) state_d = DONE;
      WAIT_RESP_HIGH: if (rise) state_d = WAIT_RESP_END;  else if (to_hit) state_d = DONE;
      WAIT_RESP_END:  if (fall) state_d = BIT_LOW;        else if (to_hit) state_d = DONE;
      BIT_LOW:        if (rise) state_d = BIT_HIGH;       else if (to_hit) state_d = DONE;
      BIT_HIGH: begin
        if (fall)        state_d = (bit_cnt_q == 6'd39) ? CHECK : BIT_LOW;
        else if (to_hit) state_d = DONE;
      end
      CHECK:          state_d = DONE;
      DONE:           state_d = HOLDOFF;
      HOLDOFF:        if (elapsed(us_cnt_q, HOLD_LAST, tick)) state_d = IDLE;
      default:        state_d = POWERUP;
    endcase
  end

  // Outputs decoded from the state register so reset releases the line at once.
  always_comb begin
    dht_oe = '0;
    if (state_q == START_LOW) dht_oe[ch_q] = 1'b1;
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Microsecond divider and counter, restarted on every state change.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt_q <= '0;
      us_cnt_q  <= '0;
    end else if (state_d != state_q) begin
      div_cnt_q <= '0;
      us_cnt_q  <= '0;
    end else if (tick) begin
      div_cnt_q <= '0;
      if (us_cnt_q != '1) us_cnt_q <= us_cnt_q + 32'd1;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

  // Channel latch and MSB-first bit shifter; a bit is 1 when its high time exceeds the threshold.
  always_ff @(posedge clock) begin
    if (reset) begin
      ch_q      <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else if (state_q == IDLE && start) begin
      ch_q      <= ch_sel;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else if (state_q == BIT_HIGH && fall) begin
      shift_q   <= {shift_q[38:0], (us_cnt_q > THRESH)};
      bit_cnt_q <= bit_cnt_q + 6'd1;
    end
  end

  // Publish results on entry to DONE; any entry not from CHECK is a timeout or bad channel.
  always_ff @(posedge clock) begin
    if (reset) begin
      data        <= '0;
      data_ch     <= '0;
      checksum_ok <= 1'b0;
      timeout_err <= 1'b0;
    end else if (state_d == DONE && state_q != DONE) begin
      data_ch     <= (state_q == IDLE) ? ch_sel : ch_q;
      timeout_err <= (state_q != CHECK);
      checksum_ok <= (state_q == CHECK) && sum_match(shift_q);
      if (state_q == CHECK && sum_match(shift_q)) data <= shift_q[39:8];
    end
  end

endmodule

// File: doc/dht_sensor_reader.md
DHT_SENSOR_READER -- requirements
Module: dht_sensor_reader

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz; CLK_HZ/1_000_000 is an integer of at least 2.
REQ-002 SHALL have parameter NUM_CH, default 4, number of single-wire sensor channels (1..16).
REQ-003 SHALL have parameter POWER_ON_US, default 1_000_000, settle time after reset before the first transaction.
REQ-004 SHALL have parameter START_LOW_US, default 20_000, duration of the host start pulse.
REQ-005 SHALL have parameter BIT_THRESH_US, default 40; a bit high time above this value reads as 1.
REQ-006 SHALL have parameter TIMEOUT_US, default 100, maximum wait for any expected sensor edge.
REQ-007 SHALL have parameter HOLDOFF_US, default 2_000_000, minimum gap after one transaction's done before the next start pulse.
REQ-008 SHALL have port clock, input, 1, system clock; all logic on its rising edge.
REQ-009 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-010 SHALL have port start, input, 1, one-cycle request for a read.
REQ-011 SHALL have port ch_sel, input, CH_W = max(1, clog2(NUM_CH)), channel to read; sampled when start is accepted.
REQ-012 SHALL have port dht_in, input, NUM_CH, per-channel line level (asynchronous).
REQ-013 SHALL have port dht_oe, output, NUM_CH; a 1 drives that line low, a 0 releases it. The top level makes the line open-drain.
REQ-014 SHALL have port busy, output, 1, high from reset until the module is idle and can accept start.
REQ-015 SHALL have port done, output, 1, one-cycle pulse at the end of every accepted transaction.
REQ-016 SHALL have port data, output, 32, {byte4, byte3, byte2, byte1} of the last valid frame.
REQ-017 SHALL have port data_ch, output, CH_W, channel of the last completed transaction.
REQ-018 SHALL have port checksum_ok, output, 1, last transaction completed and its checksum matched.
REQ-019 SHALL have port timeout_err, output, 1, last transaction aborted on a timeout.

Function
REQ-020 SHALL derive a 1 us tick from a divider counting CLK_HZ/1_000_000 clocks; all *_US timing is counted in ticks.
REQ-021 SHALL pass each dht_in bit through a 2-flop synchronizer, then detect edges on the selected channel by comparing with its previous value.
REQ-022 SHALL implement the state machine: POWERUP -> IDLE -> START_LOW -> WAIT_RESP_LOW -> WAIT_RESP_HIGH -> WAIT_RESP_END -> BIT_LOW -> BIT_HIGH -> (BIT_LOW or CHECK) -> DONE -> HOLDOFF -> IDLE.
REQ-023 SHALL, in POWERUP, release all lines and go to IDLE after POWER_ON_US.
REQ-024 SHALL, in IDLE, on start, latch ch_sel and go to START_LOW; ch_sel >= NUM_CH ends the transaction immediately with done and timeout_err=1.
REQ-025 SHALL, in START_LOW, drive dht_oe[ch] = 1 for START_LOW_US, then release the line and clear the us counter.
REQ-026 SHALL wait for edges in this order: falling edge (WAIT_RESP_LOW), rising edge (WAIT_RESP_HIGH), falling edge (WAIT_RESP_END); each wait is bounded by TIMEOUT_US.
REQ-027 SHALL, in BIT_LOW, wait for a rising edge; in BIT_HIGH, count the high time until the falling edge. Each wait is bounded by TIMEOUT_US.
REQ-028 SHALL shift each received bit into a 40-bit register, MSB first; the bit value is 1 when the high time exceeds BIT_THRESH_US, otherwise 0.
REQ-029 SHALL enter CHECK after the 40th falling edge; checksum_ok = (byte4 + byte3 + byte2 + byte1) mod 256 == byte0.
REQ-030 SHALL, on a good checksum, update data and data_ch at DONE; on a bad checksum or timeout, leave data unchanged and update data_ch, checksum_ok and timeout_err.
REQ-031 SHALL, on any timeout, release the line and go to DONE with timeout_err=1 and checksum_ok=0.
REQ-032 SHALL pulse done for exactly one clock in DONE, then wait HOLDOFF_US in HOLDOFF with busy=1.
REQ-033 SHALL ignore start while busy=1; start is not queued.
REQ-034 SHALL drive dht_oe high only for the selected channel and only in START_LOW; all other channels stay 0 at all times.

Reset
REQ-035 SHALL, with reset high at a clock edge, go to POWERUP and set dht_oe=0, busy=1, done=0, data=0, data_ch=0, checksum_ok=0, timeout_err=0, clear all counters and the shift register, and release the line within the same clock even mid-transaction.

Verification (sim with CLK_HZ=4_000_000, POWER_ON_US=10, START_LOW_US=50, HOLDOFF_US=20)
REQ-036 SHALL cover reset: after reset, dht_oe=0, busy=1 for 10 us, then busy=0 and all outputs zero.
REQ-037 SHALL cover a good frame: ch_sel=2, sensor model sends 0x37,0x00,0x19,0x00,0x50 (0 = 26 us high, 1 = 70 us high) -> dht_oe[2] low 50 us, done pulse, data=0x37001900, checksum_ok=1, data_ch=2.
REQ-038 SHALL cover a bad checksum: same frame with checksum 0x51 -> done, checksum_ok=0, timeout_err=0, data still 0x37001900.
REQ-039 SHALL cover no sensor response: line stays high after release -> timeout_err=1 about 100 us after release, done pulses, busy clears after holdoff.
REQ-040 SHALL cover start while busy: start during a transaction and during HOLDOFF -> ignored, exactly one done.
REQ-041 SHALL cover reset mid-frame: reset after bit 17 -> line released next clock, no done pulse, POWERUP restarts.
